pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register; successor to the fixed MEM/WB latch.
- Carries an opaque payload with a valid/ready handshake, synchronous flush and back-pressure.
- Optional 2-entry skid mode gives a registered in_ready, so stall does not ripple combinationally through stages.
- Instantiated between EX/MEM, MEM/WB and any future stages; WB fields are packed by the shared package.

Parameters:
- WIDTH, 71, payload bits (default = sel_wb 1 + reg_rw 1 + addr_dst 5 + alu_result 32 + data_out 32).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous flush: discard all held beats.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  downstream payload.
- occupancy  output  2  beats held (0..2; max 1 when SKID=0).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Single clock, synchronous active-high reset.
- Reset values: out_valid=0, out_data=0, occupancy=0, stall_cnt=0, skid entry invalid and zeroed. in_ready=0 while rst is high, and 1 at the first edge after rst falls.
- Transfers occur only when valid and ready are both 1 at a rising edge. Latency is 1 cycle from an in-handshake to out_valid when the stage is empty.
- SKID=1 state machine (main = output register, skid = overflow entry):
  - EMPTY: in-hs -> FULL (main <= in_data).
  - FULL, in-hs and out-hs -> FULL (main <= in_data).
  - FULL, out-hs only -> EMPTY.
  - FULL, in-hs only -> SKID (skid <= in_data).
  - FULL, neither -> FULL (hold).
  - SKID: in_ready=0; out-hs -> FULL (main <= skid); otherwise hold.
  - in_ready is registered: 1 in EMPTY and FULL, 0 in SKID.
- SKID=0: in_ready = !out_valid | out_ready (combinational). Main register only. occupancy never exceeds 1.
- Beat order is strictly FIFO. No beat is duplicated or dropped except by flush or reset.
- Data hold: out_data is stable while out_valid=1 and out_ready=0.
- Flush at an edge:
  - An out-hs in the same cycle completes normally.
  - All held beats are invalidated. main and skid payloads are zeroed. State -> EMPTY.
  - An in-hs in the same cycle is consumed and discarded.
  - in_ready=1 the next cycle.
- rst and flush together: rst dominates; stall_cnt clears on rst only, never on flush.
- stall_cnt increments by 1 on each edge where out_valid=1 and out_ready=0. It saturates at 2^CNT_W-1.
- Reset mid-operation: all state is dropped at that edge; no partial beat is emitted.
- occupancy: 0 = EMPTY, 1 = FULL, 2 = SKID. It is registered and tracks the state.

Decomposition:
- Package pipe_pkg holds:
  - WB field widths and offsets: SEL_WB_BIT=70, REG_RW_BIT=69, ADDR_DST 68:64, ALU_RESULT 63:32, DATA_OUT 31:0.
  - WB_WIDTH=71.
  - State encoding ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2.
- No sub-module. The SKID=0/1 variants are generate branches in one module.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=0, occupancy=0. in_ready=1 the cycle after rst falls.
- Stream, out_ready=1: inject 0x1, 0x2, 0x3 on consecutive cycles -> out_data 0x1, 0x2, 0x3 one cycle later each; occupancy stays 1; stall_cnt=0.
- Back-pressure, SKID=1: out_ready=0, inject 0xA then 0xB -> occupancy 2, in_ready=0, out_data stays 0xA. Raise out_ready -> 0xA then 0xB out; in_ready returns to 1; stall_cnt equals the stalled cycles.
- Flush in SKID state while offering 0xC -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; 0xC is never output.
- SKID=0, out_ready=0 with out_valid=1 -> in_ready=0 combinationally. out_ready=1 plus in_valid=1 with 0x5 -> 0x5 out the next cycle with no bubble.
- Saturation with CNT_W=4: stall for 20 cycles -> stall_cnt=15 and holds. A following rst -> 0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for elastic pipeline-stage registers: write-back
// payload layout and the stage occupancy/state encoding.
package pipe_pkg;

    // Write-back payload field positions
    localparam int SEL_WB_BIT    = 70;
    localparam int REG_RW_BIT    = 69;
    localparam int ADDR_DST_HI   = 68;
    localparam int ADDR_DST_LO   = 64;
    localparam int ALU_RESULT_HI = 63;
    localparam int ALU_RESULT_LO = 32;
    localparam int DATA_OUT_HI   = 31;
    localparam int DATA_OUT_LO   = 0;
    localparam int WB_WIDTH      = 71;

    // Stage state; the numeric value doubles as the occupancy count
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    // Pack the write-back fields into one stage payload
    function automatic logic [WB_WIDTH-1:0] wb_pack(
        input logic        sel_wb,
        input logic        reg_rw,
        input logic [4:0]  addr_dst,
        input logic [31:0] alu_result,
        input logic [31:0] data_out
    );
        logic [WB_WIDTH-1:0] pkt;
        pkt                              = {WB_WIDTH{1'b0}};
        pkt[SEL_WB_BIT]                  = sel_wb;
        pkt[REG_RW_BIT]                  = reg_rw;
        pkt[ADDR_DST_HI:ADDR_DST_LO]     = addr_dst;
        pkt[ALU_RESULT_HI:ALU_RESULT_LO] = alu_result;
        pkt[DATA_OUT_HI:DATA_OUT_LO]     = data_out;
        return pkt;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, synchronous
// flush and a saturating stall counter. SKID=1 adds an overflow entry so
// in_ready is registered; SKID=0 is a single register with a
// combinational in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

    logic             in_hs_s;
    logic             out_hs_s;
    logic [CNT_W-1:0] stall_q;

    assign in_hs_s   = in_valid & in_ready;
    assign out_hs_s  = out_valid & out_ready;
    assign stall_cnt = stall_q;

    // Count edges where a beat is offered but not taken; flush does not clear it
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= {CNT_W{1'b0}};
        end else if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end else begin
            stall_q <= stall_q;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_e      state_q, state_d;
            logic [WIDTH-1:0] main_q, main_d;
            logic [WIDTH-1:0] skid_q, skid_d;
            logic             in_ready_q;
            logic             out_valid_q;
            logic [1:0]       occ_q;

            // Next state and payload movement between input, main and skid entry
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = ST_EMPTY;
                    main_d  = DATA_ZERO;
                    skid_d  = DATA_ZERO;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_hs_s) begin
                                state_d = ST_FULL;
                                main_d  = in_data;
                            end else begin
                                state_d = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (in_hs_s && out_hs_s) begin
                                main_d = in_data;
                            end else if (out_hs_s) begin
                                state_d = ST_EMPTY;
                            end else if (in_hs_s) begin
                                state_d = ST_SKID;
                                skid_d  = in_data;
                            end else begin
                                state_d = ST_FULL;
                            end
                        end
                        ST_SKID: begin
                            if (out_hs_s) begin
                                state_d = ST_FULL;
                                main_d  = skid_q;
                                skid_d  = DATA_ZERO;
                            end else begin
                                state_d = ST_SKID;
                            end
                        end
                        default: begin
                            state_d = ST_EMPTY;
                            main_d  = DATA_ZERO;
                            skid_d  = DATA_ZERO;
                        end
                    endcase
                end
            end

            // State register with registered handshake outputs derived from next state
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q     <= ST_EMPTY;
                    main_q      <= DATA_ZERO;
                    skid_q      <= DATA_ZERO;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    occ_q       <= 2'd0;
                end else begin
                    state_q     <= state_d;
                    main_q      <= main_d;
                    skid_q      <= skid_d;
                    in_ready_q  <= (state_d != ST_SKID);
                    out_valid_q <= (state_d != ST_EMPTY);
                    occ_q       <= 2'(state_d);
                end
            end

            assign in_ready  = in_ready_q;
            assign out_valid = out_valid_q;
            assign out_data  = main_q;
            assign occupancy = occ_q;
        end else begin : g_single
            logic [WIDTH-1:0] main_q, main_d;
            logic             valid_q, valid_d;
            logic             live_q;

            // Load on input handshake, empty on output handshake, clear on flush
            always_comb begin
                valid_d = valid_q;
                main_d  = main_q;
                if (flush) begin
                    valid_d = 1'b0;
                    main_d  = DATA_ZERO;
                end else if (in_hs_s) begin
                    valid_d = 1'b1;
                    main_d  = in_data;
                end else if (out_hs_s) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end

            // Main register plus a flag that keeps in_ready low through reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    main_q  <= DATA_ZERO;
                    live_q  <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                    main_q  <= main_d;
                    live_q  <= 1'b1;
                end
            end

            assign in_ready  = live_q & (~valid_q | out_ready);
            assign out_valid = valid_q;
            assign out_data  = main_q;
            assign occupancy = {1'b0, valid_q};
        end
    endgenerate

endmodule
